ppu_ram_emulator: RTL

//  Responder end of the PPU's nibble-serial RAM interface: watches the PPU addr_pins, collects address

---
 rtl/ppu_ram_emulator_pkg.sv | 29 ++
 rtl/ppu_ram_emulator_mem.sv | 39 +++
 rtl/ppu_ram_emulator.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ppu_ram_emulator_pkg.sv
// ---------------------------------------------------------------------------
// ppu_ram_emulator_pkg
//   Shared constants and types for the PPU nibble-serial RAM responder.
//   The same definitions are used by the PPU-side bench monitor, so frame
//   markers and state encodings live here rather than in the RTL bodies.
// ---------------------------------------------------------------------------
package ppu_ram_emulator_pkg;

  localparam logic [3:0] START_NIBBLE = 4'b0001;
  localparam logic [3:0] IDLE_NIBBLE  = 4'b0000;
  localparam int         ADDR_NIBBLES = 4;
  localparam int         DATA_NIBBLES = 4;
  localparam int         WORD_BITS    = 16;

  // Frame FSM: one state per address nibble, MSB nibble (A3) first.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_A3   = 3'd1,
    ST_A2   = 3'd2,
    ST_A1   = 3'd3,
    ST_A0   = 3'd4
  } frame_state_e;

  // A nibble in IDLE that is neither idle nor START is a reserved code.
  function automatic logic is_reserved(input logic [3:0] nib);
    return (nib != IDLE_NIBBLE) && (nib != START_NIBBLE);
  endfunction

endpackage

// File: rtl/ppu_ram_emulator_mem.sv
// ---------------------------------------------------------------------------
// ram_emu_mem
//   Single-port-write / single-port-read word memory with a synchronous,
//   read-before-write read port: a read and a write to the same word on the
//   same edge return the word's previous contents.
// Ports
//   clk    in   clock
//   we     in   write strobe
//   waddr  in   write word address
//   wdata  in   write word
//   re     in   read strobe (rdata updates only when re is high)
//   raddr  in   read word address
//   rdata  out  registered read word
// ---------------------------------------------------------------------------
module ram_emu_mem #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  // NOTE: storage and its read register carry no reset so the array maps
  // onto block RAM; contents survive rst_n, and validity is tracked outside.
  // NOTE: non-blocking assignments make the read sample mem before the
  // write lands, which is exactly the read-before-write behaviour wanted.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ppu_ram_emulator.sv
// ---------------------------------------------------------------------------
// ppu_ram_emulator
//   Responder end of the PPU nibble-serial RAM interface. Watches addr_pins
//   for START followed by four address nibbles (MSB first), reads the 16-bit
//   word at addr[MEM_ADDR_BITS-1:0] and streams it back on data_pins LSB
//   nibble first, starting LATENCY cycles after the last address nibble.
//   Optional statistics counters are enabled by defining RAM_EMU_STATS_EN.
// Parameters
//   RAM_PINS       pin width (only 4 supported)
//   MEM_ADDR_BITS  log2 of memory depth in 16-bit words
//   LATENCY        last address nibble -> first data nibble, 2..8
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   addr_pins      in   START marker and address nibbles from the PPU
//   data_pins      out  registered response nibbles, 0 when idle
//   ld_en/addr/data in  host preload write port
//   req_count      out  accepted frames (0 unless RAM_EMU_STATS_EN)
//   err_count      out  reserved IDLE nibbles, saturating (0 unless enabled)
// ---------------------------------------------------------------------------
module ppu_ram_emulator
  import ppu_ram_emulator_pkg::*;
#(
  parameter int RAM_PINS      = 4,
  parameter int MEM_ADDR_BITS = 10,
  parameter int LATENCY       = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [RAM_PINS-1:0]      addr_pins,
  output logic [RAM_PINS-1:0]      data_pins,
  input  logic                     ld_en,
  input  logic [MEM_ADDR_BITS-1:0] ld_addr,
  input  logic [WORD_BITS-1:0]     ld_data,
  output logic [15:0]              req_count,
  output logic [7:0]               err_count
);

  frame_state_e         state;
  logic [11:0]          addr_sh;     // first three address nibbles
  logic [15:0]          full_addr;
  logic                 rd_en;
  logic                 rd_valid;
  logic [WORD_BITS-1:0] rd_data;
  logic                 fin_valid;
  logic [WORD_BITS-1:0] fin_data;
  logic [11:0]          out_sh;      // nibbles still to be sent
  logic [1:0]           out_cnt;

  // -------------------------------------------------------------------------
  // Frame FSM and address collection. Address nibbles are taken verbatim,
  // even if one happens to equal START.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      addr_sh <= '0;
    end else begin
      case (state)
        ST_IDLE: if (addr_pins == START_NIBBLE) state <= ST_A3;
        ST_A3: begin
          addr_sh <= {addr_sh[7:0], addr_pins};
          state   <= ST_A2;
        end
        ST_A2: begin
          addr_sh <= {addr_sh[7:0], addr_pins};
          state   <= ST_A1;
        end
        ST_A1: begin
          addr_sh <= {addr_sh[7:0], addr_pins};
          state   <= ST_A0;
        end
        ST_A0:   state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The last nibble is used straight off the pins so the read is issued in
  // the A0 cycle itself; that read counts as the first latency stage.
  assign full_addr = {addr_sh, addr_pins};
  assign rd_en     = (state == ST_A0);

  generate
    if (MEM_ADDR_BITS < 16) begin : g_alias
      // Upper address bits alias onto the memory; they are deliberately dropped.
      logic unused_addr_hi;
      assign unused_addr_hi = ^full_addr[15:MEM_ADDR_BITS];
    end
  endgenerate

  ram_emu_mem #(
    .ADDR_BITS (MEM_ADDR_BITS),
    .DATA_BITS (WORD_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (ld_en),
    .waddr (ld_addr),
    .wdata (ld_data),
    .re    (rd_en),
    .raddr (full_addr[MEM_ADDR_BITS-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid <= 1'b0;
    else        rd_valid <= rd_en;
  end

  // -------------------------------------------------------------------------
  // Latency pipeline: memory read and output register supply two stages, so
  // LATENCY-2 extra {valid,data} stages sit between them. Frame spacing
  // guarantees one word in flight per stage, so no FIFO is needed.
  // -------------------------------------------------------------------------
  generate
    if (LATENCY > 2) begin : g_pipe
      localparam int DEPTH = LATENCY - 2;
      logic [DEPTH-1:0]     pv;
      logic [WORD_BITS-1:0] pd [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pv <= '0;
        end else begin
          pv[0] <= rd_valid;
          for (int i = 1; i < DEPTH; i++) pv[i] <= pv[i-1];
        end
      end

      always_ff @(posedge clk) begin
        pd[0] <= rd_data;
        for (int i = 1; i < DEPTH; i++) pd[i] <= pd[i-1];
      end

      assign fin_valid = pv[DEPTH-1];
      assign fin_data  = pd[DEPTH-1];
    end else begin : g_nopipe
      assign fin_valid = rd_valid;
      assign fin_data  = rd_data;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Output nibble shifter: LSB nibble first, then 0 once the word is out.
  // Reset clears it immediately, so a burst in progress is cut off.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_pins <= '0;
      out_sh    <= '0;
      out_cnt   <= '0;
    end else if (fin_valid) begin
      data_pins <= fin_data[3:0];
      out_sh    <= fin_data[15:4];
      out_cnt   <= 2'd3;
    end else if (out_cnt != 2'd0) begin
      data_pins <= out_sh[3:0];
      out_sh    <= {4'h0, out_sh[11:4]};
      out_cnt   <= out_cnt - 2'd1;
    end else begin
      data_pins <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // Statistics
  // -------------------------------------------------------------------------
`ifdef RAM_EMU_STATS_EN
  logic [15:0] req_q;
  logic [7:0]  err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
      err_q <= '0;
    end else begin
      if (state == ST_A0) req_q <= req_q + 16'd1;
      if (state == ST_IDLE && is_reserved(addr_pins) && err_q != 8'hFF)
        err_q <= err_q + 8'd1;
    end
  end

  assign req_count = req_q;
  assign err_count = err_q;
`else
  assign req_count = '0;
  assign err_count = '0;
`endif

endmodule
